// File: rtl/lane_demux_pkg.sv
// lane_demux_pkg: shared states, light codes and axis masks for the lane demux.
package lane_demux_pkg;
  typedef enum logic [1:0] {COLLECT, COMMIT, FAULT} state_t;
  localparam logic [2:0] CODE_RED = 3'b100;
  localparam logic [2:0] CODE_YEL = 3'b010;
  localparam logic [2:0] CODE_GRN = 3'b001;
  localparam logic [11:0] ALL_RED = {4{CODE_RED}};
  localparam logic [3:0] AXIS_A = 4'b0101;
  localparam logic [3:0] AXIS_B = 4'b1010;
endpackage

// File: rtl/lane_frame_check.sv
// lane_frame_check: combinational legality check of a staged four-lane frame.
module lane_frame_check
  import lane_demux_pkg::*;
(
  input  logic [11:0] shadow,
  output logic        onehot_ok,
  output logic        axis_ok
);
  logic [3:0] oh;
  logic [3:0] live;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign oh[i]   = $onehot(shadow[3*i +: 3]);
    assign live[i] = shadow[3*i +: 3] != CODE_RED;
  end
  assign onehot_ok = &oh;
  assign axis_ok   = !(|(live & AXIS_A) && |(live & AXIS_B));
endmodule

// File: rtl/lane_demux_1to4.sv
// lane_demux_1to4: stages lane-code beats into shadow registers and commits whole frames atomically.
// STALE_TIMEOUT_EN adds a stale-commit timer that forces FAULT after TIMEOUT_CYC idle cycles.
module lane_demux_1to4
  import lane_demux_pkg::*;
#(
  parameter int CODE_W = 3
`ifdef STALE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_last,
  input  logic                clear_fault,
  output logic [4*CODE_W-1:0] lane_code,
  output logic                commit,
  output logic                fault,
  output logic                frame_err
);
  state_t      state;
  logic [11:0] shadow;
  logic [3:0]  mask;
  logic        onehot_ok;
  logic        axis_ok;
  logic        acc;
  logic        stale;
  assign acc = in_valid && in_ready;
  lane_frame_check u_check (
    .shadow    (shadow),
    .onehot_ok (onehot_ok),
    .axis_ok   (axis_ok)
  );
`ifdef STALE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmr <= '0;
    else tmr <= ((state == COMMIT && onehot_ok && axis_ok && &mask) || (state == FAULT && clear_fault))
                ? '0 : tmr + TW'(tmr != TW'(TIMEOUT_CYC));
  assign stale = state == COLLECT && tmr >= TW'(TIMEOUT_CYC - 1);
`else
  assign stale = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      shadow    <= ALL_RED;
      mask      <= '0;
      lane_code <= ALL_RED;
      in_ready  <= 1'b0;
      commit    <= 1'b0;
      fault     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      commit    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (stale) begin
            state     <= FAULT;
            lane_code <= ALL_RED;
            fault     <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            in_ready <= !(acc && in_last);
            if (acc) begin
              shadow[CODE_W*in_sel +: CODE_W] <= in_code;
              mask[in_sel] <= 1'b1;
              if (in_last) state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          mask <= '0;
          if (!(onehot_ok && axis_ok)) begin
            state     <= FAULT;
            frame_err <= 1'b1;
            fault     <= 1'b1;
            lane_code <= ALL_RED;
          end else begin
            state    <= COLLECT;
            in_ready <= 1'b1;
            if (&mask) begin
              lane_code <= shadow;
              commit    <= 1'b1;
            end else frame_err <= 1'b1;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state    <= COLLECT;
            in_ready <= 1'b1;
            fault    <= 1'b0;
            shadow   <= ALL_RED;
            mask     <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_demux_1to4.sv
// tb_lane_demux_1to4: frame-level model plus per-cycle compare for lane_demux_1to4.
// Build with STALE_TIMEOUT_EN to exercise the stale timer (TIMEOUT_CYC=20).
module tb_lane_demux_1to4;
  import lane_demux_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = '0;
  logic [2:0]  in_code = '0;
  logic        in_last = 1'b0;
  logic        clear_fault = 1'b0;
  logic [11:0] lane_code;
  logic        commit;
  logic        fault;
  logic        frame_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0]  m_sh [4];
  logic [3:0]  m_mask;
  logic [11:0] exp_lane;
  logic        exp_ready, exp_commit, exp_fault, exp_err;
  bit          checking = 0;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  always #5 clk = ~clk;
`ifdef STALE_TIMEOUT_EN
  lane_demux_1to4 #(.TIMEOUT_CYC(20)) dut (
`else
  lane_demux_1to4 dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_code     (in_code),
    .in_last     (in_last),
    .clear_fault (clear_fault),
    .lane_code   (lane_code),
    .commit      (commit),
    .fault       (fault),
    .frame_err   (frame_err)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (checking) begin
      chk("lane_code", lane_code, exp_lane);
      chk("in_ready", 12'(in_ready), 12'(exp_ready));
      chk("commit", 12'(commit), 12'(exp_commit));
      chk("fault", 12'(fault), 12'(exp_fault));
      chk("frame_err", 12'(frame_err), 12'(exp_err));
    end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_sh[i] = R;
    m_mask = '0;
  endtask

  // Frame verdict straight from the rules: legal codes, axis exclusivity, completeness.
  task automatic judge();
    bit bad_code = 0;
    bit a_live, b_live;
    for (int i = 0; i < 4; i++)
      if (!(m_sh[i] inside {R, Y, G})) bad_code = 1;
    a_live = m_sh[0] != R || m_sh[2] != R;
    b_live = m_sh[1] != R || m_sh[3] != R;
    if (bad_code || (a_live && b_live)) begin
      exp_err = 1; exp_fault = 1; exp_lane = ALL_RED; exp_ready = 0;
    end else if (m_mask != 4'hf) begin
      exp_err = 1; exp_ready = 1;
    end else begin
      exp_commit = 1; exp_ready = 1;
      exp_lane = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
    end
    m_mask = '0;
  endtask

  task automatic beat(input logic [1:0] s, input logic [2:0] c, input logic l);
    in_valid = 1; in_sel = s; in_code = c; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    m_sh[s] = c;
    m_mask[s] = 1'b1;
    if (l) begin
      exp_ready = 0;
      @(posedge clk); #1;
      judge();
      @(posedge clk); #1;
      exp_commit = 0; exp_err = 0;
    end
  endtask

  task automatic clear();
    clear_fault = 1;
    @(posedge clk); #1;
    clear_fault = 0;
    exp_fault = 0; exp_ready = 1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    exp_lane = ALL_RED; exp_ready = 0; exp_commit = 0; exp_fault = 0; exp_err = 0;
    #2 rst_n = 0;
    #1 checking = 1;
    chk("rst lane", lane_code, 12'h924);
    chk("rst ready", 12'(in_ready), 12'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1 exp_ready = 1;
    // legal frame
    beat(0, G, 0); beat(1, R, 0); beat(2, G, 0); beat(3, R, 1);
    chk("legal lane", lane_code, 12'b100_001_100_001);
    // incomplete frame, then a full one
    beat(0, Y, 0); beat(2, Y, 1);
    chk("incomplete lane", lane_code, 12'b100_001_100_001);
    chk("incomplete fault", 12'(fault), 12'h0);
    beat(0, R, 0); beat(1, Y, 0); beat(2, R, 0); beat(3, G, 1);
    chk("recover lane", lane_code, 12'b001_100_010_100);
    // axis conflict
    beat(0, G, 0); beat(1, G, 0); beat(2, R, 0); beat(3, R, 1);
    chk("conflict fault", 12'(fault), 12'h1);
    chk("conflict lane", lane_code, 12'h924);
    in_valid = 1; in_sel = 0; in_code = G;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    clear();
    chk("cleared ready", 12'(in_ready), 12'h1);
    // bad code after an overwrite
    beat(1, R, 0); beat(1, 3'b011, 1);
    chk("badcode fault", 12'(fault), 12'h1);
    clear();
    // bad code overwritten by a legal one
    beat(1, 3'b011, 0); beat(1, R, 0); beat(0, R, 0); beat(2, G, 0); beat(3, R, 1);
    chk("overwrite lane", lane_code, 12'b100_001_100_100);
`ifdef STALE_TIMEOUT_EN
    repeat (18) @(posedge clk);
    #1 chk("stale early", 12'(fault), 12'h0);
    @(posedge clk); #1;
    exp_fault = 1; exp_lane = ALL_RED; exp_ready = 0;
    chk("stale fault", 12'(fault), 12'h1);
    chk("stale no err", 12'(frame_err), 12'h0);
    clear();
`else
    repeat (100) @(posedge clk);
    #1 chk("hold lane", lane_code, 12'b100_001_100_100);
    chk("hold fault", 12'(fault), 12'h0);
`endif
    // reset in the middle of a frame
    beat(0, Y, 0); beat(1, G, 0);
    @(negedge clk); #2;
    rst_n = 0;
    model_reset();
    exp_lane = ALL_RED; exp_ready = 0; exp_commit = 0; exp_err = 0; exp_fault = 0;
    #1;
    chk("midrst lane", lane_code, 12'h924);
    chk("midrst ready", 12'(in_ready), 12'h0);
    chk("midrst commit", 12'(commit), 12'h0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 exp_ready = 1;
    beat(1, R, 1);
    chk("post-rst lane", lane_code, 12'h924);
    repeat (3) @(posedge clk);
    #1 checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
